mem_stage_unit: RTL and testbench

- Memory stage of the 5-stage ARM-subset pipeline, directly downstream of the execute stage.
- Consumes the registered EXE outputs: ALU result as the address, Val_Rm as store data, plus the control bits.
- Performs loads and stores against an internal word-addressed data memory with a fixed multi-cycle access latency, and stalls upstream stages while an access is in flight.
- Contains the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_stage_unit_pkg.sv | 26 ++
 rtl/mem_stage_unit_mem_wb.sv | 29 ++
 rtl/mem_stage_unit.sv | 193 +++++++++++++++++++
 tb/tb_mem_stage_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_unit_pkg.sv
// Shared definitions for the memory stage: FSM state encoding, the MEM/WB
// register payload and its bubble value, and the datapath widths.
package mem_stage_unit_pkg;

    localparam int          REG_IDX_W         = 4;
    localparam int          DATA_W            = 32;
    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic                 wb_enable;
        logic                 mem_read_enable;
        logic [REG_IDX_W-1:0] dest;
        logic [DATA_W-1:0]    alu_result;
        logic [DATA_W-1:0]    mem_data;
    } mem_wb_t;

    // A bubble writes nothing back and carries no data.
    localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_stage_unit_mem_wb.sv
// MEM/WB pipeline register: a flop bank that either captures the stage
// result or loads a bubble when the stage has nothing to hand on.
module mem_wb_stage_reg
    import mem_stage_unit_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    bubble_i,
    input  mem_wb_t d_i,
    output mem_wb_t q_o
);

    mem_wb_t wb_q;

    // Capture the stage result, or a bubble, on every rising edge.
    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q <= MEM_WB_BUBBLE;
        end else if (bubble_i) begin
            wb_q <= MEM_WB_BUBBLE;
        end else begin
            wb_q <= d_i;
        end
    end

    assign q_o = wb_q;

endmodule

// File: rtl/mem_stage_unit.sv
// Memory stage of the 5-stage pipeline: multi-cycle access to a word-addressed
// data array, upstream stall while an access is in flight, MEM/WB register.
// Optional build macro MEM_BOUNDS_CHECK_EN: out-of-range addresses suppress
// stores, read as zero and set a sticky addr_error; without it the word index
// wraps modulo DEPTH and addr_error is held low.
module mem_stage_unit
    import mem_stage_unit_pkg::*;
#(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int          MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_enable,
    input  logic                 mem_read_enable,
    input  logic                 mem_write_enable,
    input  logic [REG_IDX_W-1:0] dest,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic [DATA_W-1:0]    val_rm,
    output logic                 stall,
    output logic                 wb_enable_out,
    output logic                 mem_read_enable_out,
    output logic [REG_IDX_W-1:0] dest_out,
    output logic [DATA_W-1:0]    alu_result_out,
    output logic [DATA_W-1:0]    mem_data_out,
    output logic                 addr_error
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              req;
    logic              is_store;
    logic              is_load;
    logic [31:0]       offset;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              unused_offset_bits;

    logic              stall_raw;
    logic              bubble;
    logic              mem_we;
    mem_wb_t           wb_d;
    mem_wb_t           wb_q;

    // A simultaneous read and write request is a store.
    assign req      = mem_read_enable | mem_write_enable;
    assign is_store = mem_write_enable;
    assign is_load  = mem_read_enable & ~mem_write_enable;

    // Byte address to word index; the two low address bits are ignored.
    assign offset = alu_result - BASE_ADDR;
    assign idx    = offset[IDX_W+1:2];

`ifdef MEM_BOUNDS_CHECK_EN
    // Addresses below BASE_ADDR wrap to huge offsets and fail this test too.
    assign in_range           = (offset < 32'(4 * DEPTH));
    assign unused_offset_bits = ^offset[1:0];
`else
    assign in_range           = 1'b1;
    assign unused_offset_bits = ^{offset[31:IDX_W+2], offset[1:0]};
`endif

    // FSM state and latency counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE -> (WAIT ->) DONE -> IDLE for every access.
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MEM_IDLE: begin
                if (req) begin
                    cnt_d   = CNT_W'(1);
                    state_d = (MEM_LATENCY == 1) ? MEM_DONE : MEM_WAIT;
                end else begin
                    cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = MEM_DONE;
                end
            end
            MEM_DONE: begin
                cnt_d   = '0;
                state_d = MEM_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = MEM_IDLE;
            end
        endcase
    end

    // Output logic: stall, bubble insertion, array write strobe, MEM/WB payload.
    always_comb begin
        stall_raw = 1'b0;
        bubble    = 1'b1;
        mem_we    = 1'b0;
        wb_d      = MEM_WB_BUBBLE;
        unique case (state_q)
            MEM_IDLE: begin
                if (req) begin
                    stall_raw = 1'b1;
                end else begin
                    bubble               = 1'b0;
                    wb_d.wb_enable       = wb_enable;
                    wb_d.mem_read_enable = mem_read_enable;
                    wb_d.dest            = dest;
                    wb_d.alu_result      = alu_result;
                end
            end
            MEM_WAIT: begin
                stall_raw = 1'b1;
            end
            MEM_DONE: begin
                bubble               = 1'b0;
                mem_we               = is_store & in_range;
                wb_d.wb_enable       = wb_enable;
                wb_d.mem_read_enable = is_load;
                wb_d.dest            = dest;
                wb_d.alu_result      = alu_result;
                if (is_load && in_range) begin
                    wb_d.mem_data = mem_q[idx];
                end
            end
            default: begin
                stall_raw = 1'b0;
            end
        endcase
    end

    // Stall is combinational from the request, so it is forced low in reset.
    assign stall = stall_raw & rst;

    // Data array write port; the write strobe only exists in DONE, so an
    // access abandoned by reset never commits.
    // NOTE: the array has no reset; only control state is cleared, contents persist.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= val_rm;
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    logic addr_error_q;

    // Sticky out-of-range flag, raised at the edge that completes the access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_error_q <= 1'b0;
        end else if (state_q == MEM_DONE && !in_range) begin
            addr_error_q <= 1'b1;
        end
    end

    assign addr_error = addr_error_q;
`else
    assign addr_error = 1'b0;
`endif

    mem_wb_stage_reg u_mem_wb (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (bubble),
        .d_i      (wb_d),
        .q_o      (wb_q)
    );

    assign wb_enable_out       = wb_q.wb_enable;
    assign mem_read_enable_out = wb_q.mem_read_enable;
    assign dest_out            = wb_q.dest;
    assign alu_result_out      = wb_q.alu_result;
    assign mem_data_out        = wb_q.mem_data;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Self-checking bench for mem_stage_unit: a table of directed accesses with
// hand-computed MEM/WB results and stall patterns, plus hand-written
// sequences for reset, reset during an access, and out-of-range addresses.
module tb_mem_stage_unit;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;
    localparam int NV    = 11;

    logic        clk;
    logic        rst;
    logic        wb_enable;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [3:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] val_rm;
    logic        stall;
    logic        wb_enable_out;
    logic        mem_read_enable_out;
    logic [3:0]  dest_out;
    logic [31:0] alu_result_out;
    logic [31:0] mem_data_out;
    logic        addr_error;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        wb;
        logic        rd;
        logic        wr;
        logic [3:0]  dst;
        logic [31:0] alu;
        logic [31:0] val;
        logic        e_wb;
        logic        e_rd;
        logic [3:0]  e_dst;
        logic [31:0] e_alu;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[NV];

    mem_stage_unit #(
        .DEPTH       (DEPTH),
        .BASE_ADDR   (32'd1024),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .wb_enable           (wb_enable),
        .mem_read_enable     (mem_read_enable),
        .mem_write_enable    (mem_write_enable),
        .dest                (dest),
        .alu_result          (alu_result),
        .val_rm              (val_rm),
        .stall               (stall),
        .wb_enable_out       (wb_enable_out),
        .mem_read_enable_out (mem_read_enable_out),
        .dest_out            (dest_out),
        .alu_result_out      (alu_result_out),
        .mem_data_out        (mem_data_out),
        .addr_error          (addr_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] outs_now();
        return {2'b00, wb_enable_out, mem_read_enable_out, dest_out, alu_result_out, mem_data_out};
    endfunction

    function automatic logic [71:0] pack_exp(input logic e_wb, input logic e_rd, input logic [3:0] e_dst,
                                             input logic [31:0] e_alu, input logic [31:0] e_data);
        return {2'b00, e_wb, e_rd, e_dst, e_alu, e_data};
    endfunction

    function automatic vec_t mk(input logic wb, input logic rd, input logic wr, input logic [3:0] dst,
                                input logic [31:0] alu, input logic [31:0] val,
                                input logic e_wb, input logic e_rd, input logic [3:0] e_dst,
                                input logic [31:0] e_alu, input logic [31:0] e_data);
        vec_t v;
        v.wb = wb; v.rd = rd; v.wr = wr; v.dst = dst; v.alu = alu; v.val = val;
        v.e_wb = e_wb; v.e_rd = e_rd; v.e_dst = e_dst; v.e_alu = e_alu; v.e_data = e_data;
        return v;
    endfunction

    // Drive one operation at a falling edge, hold it while stalled, check the
    // stall pattern and bubbles, then the MEM/WB result. Returns on a falling edge.
    task automatic apply(input vec_t v, input string tag);
        int n;
        wb_enable        = v.wb;
        mem_read_enable  = v.rd;
        mem_write_enable = v.wr;
        dest             = v.dst;
        alu_result       = v.alu;
        val_rm           = v.val;
        n = (v.rd || v.wr) ? LAT : 0;
        for (int i = 0; i <= n; i++) begin
            #1;
            check($sformatf("%s stall[%0d]", tag, i), 72'(stall), 72'(i < n));
            if (i > 0) begin
                check($sformatf("%s bubble[%0d]", tag, i), outs_now(), 72'd0);
            end
            @(negedge clk);
        end
        #1;
        check($sformatf("%s result", tag), outs_now(), pack_exp(v.e_wb, v.e_rd, v.e_dst, v.e_alu, v.e_data));
    endtask

    initial begin
        logic        exp_err;
        logic [31:0] exp_w0;
        logic [31:0] exp_oob;
`ifdef MEM_BOUNDS_CHECK_EN
        exp_err = 1'b1;
        exp_w0  = 32'h0000_0066;
        exp_oob = 32'h0000_0000;
`else
        exp_err = 1'b0;
        exp_w0  = 32'h0000_0077;
        exp_oob = 32'h0000_0099;
`endif

        //             wb rd wr dst  alu            val            e_wb e_rd e_dst e_alu          e_data
        vecs[0]  = mk(1, 0, 0, 4'd5,  32'h0000_1234, 32'h0,         1, 0, 4'd5,  32'h0000_1234, 32'h0);
        vecs[1]  = mk(0, 0, 1, 4'd0,  32'd1032,      32'hDEAD_BEEF, 0, 0, 4'd0,  32'd1032,      32'h0);
        vecs[2]  = mk(1, 1, 0, 4'd3,  32'd1032,      32'h0,         1, 1, 4'd3,  32'd1032,      32'hDEAD_BEEF);
        vecs[3]  = mk(0, 0, 1, 4'd0,  32'd1036,      32'h1111_1111, 0, 0, 4'd0,  32'd1036,      32'h0);
        vecs[4]  = mk(0, 0, 1, 4'd0,  32'd1040,      32'h2222_2222, 0, 0, 4'd0,  32'd1040,      32'h0);
        vecs[5]  = mk(1, 1, 0, 4'd7,  32'd1036,      32'h0,         1, 1, 4'd7,  32'd1036,      32'h1111_1111);
        vecs[6]  = mk(1, 1, 0, 4'd8,  32'd1040,      32'h0,         1, 1, 4'd8,  32'd1040,      32'h2222_2222);
        vecs[7]  = mk(0, 1, 1, 4'd0,  32'd1044,      32'h0000_3333, 0, 0, 4'd0,  32'd1044,      32'h0);
        vecs[8]  = mk(1, 1, 0, 4'd9,  32'd1044,      32'h0,         1, 1, 4'd9,  32'd1044,      32'h0000_3333);
        vecs[9]  = mk(1, 1, 0, 4'd10, 32'd1045,      32'h0,         1, 1, 4'd10, 32'd1045,      32'h0000_3333);
        vecs[10] = mk(0, 0, 0, 4'd15, 32'hFFFF_FFFF, 32'h0,         0, 0, 4'd15, 32'hFFFF_FFFF, 32'h0);

        // Reset held with random inputs: everything low, including stall.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_enable        = 1'($urandom);
            mem_read_enable  = 1'($urandom);
            mem_write_enable = 1'b1;
            dest             = 4'($urandom);
            alu_result       = $urandom;
            val_rm           = $urandom;
            @(negedge clk);
            #1;
            check($sformatf("reset outs[%0d]", i), outs_now(), 72'd0);
            check($sformatf("reset stall[%0d]", i), 72'(stall), 72'd0);
            check($sformatf("reset addr_error[%0d]", i), 72'(addr_error), 72'd0);
        end
        rst              = 1'b1;
        wb_enable        = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        dest             = '0;
        alu_result       = '0;
        val_rm           = '0;
        #1;
        check("release outs", outs_now(), 72'd0);
        @(negedge clk);

        // Table: non-memory op, store/load, back-to-back stores, store+load collision, low address bits.
        for (int i = 0; i < NV; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Out-of-range handling: word 0 seeded, then a store one past the top.
        apply(mk(0, 0, 1, 4'd0, 32'd1024, 32'h66, 0, 0, 4'd0, 32'd1024, 32'h0), "seed w0");
        check("addr_error before oob", 72'(addr_error), 72'd0);
        apply(mk(0, 0, 1, 4'd0, 32'd1280, 32'h77, 0, 0, 4'd0, 32'd1280, 32'h0), "store 1280");
        check("addr_error after oob", 72'(addr_error), 72'(exp_err));
        apply(mk(1, 0, 0, 4'd1, 32'h5, 32'h0, 1, 0, 4'd1, 32'h5, 32'h0), "nonmem after oob");
        check("addr_error sticky", 72'(addr_error), 72'(exp_err));
        apply(mk(0, 0, 1, 4'd0, 32'd1000, 32'h99, 0, 0, 4'd0, 32'd1000, 32'h0), "store 1000");
        apply(mk(1, 1, 0, 4'd1, 32'd1024, 32'h0, 1, 1, 4'd1, 32'd1024, exp_w0), "load w0");
        apply(mk(1, 1, 0, 4'd2, 32'd1000, 32'h0, 1, 1, 4'd2, 32'd1000, exp_oob), "load 1000");

        // Reset during the WAIT cycle of a store: the store must never commit.
        apply(mk(0, 0, 1, 4'd0, 32'd1040, 32'hAA, 0, 0, 4'd0, 32'd1040, 32'h0), "preload 1040");
        mem_write_enable = 1'b1;
        alu_result       = 32'd1040;
        val_rm           = 32'h55;
        #1;
        check("midrst stall idle", 72'(stall), 72'd1);
        @(negedge clk);
        #1;
        check("midrst stall wait", 72'(stall), 72'd1);
        rst = 1'b0;
        #1;
        check("midrst outs", outs_now(), 72'd0);
        check("midrst stall", 72'(stall), 72'd0);
        check("midrst addr_error", 72'(addr_error), 72'd0);
        @(negedge clk);
        #1;
        check("midrst held outs", outs_now(), 72'd0);
        rst = 1'b1;
        apply(mk(1, 0, 0, 4'd2, 32'h42, 32'h0, 1, 0, 4'd2, 32'h42, 32'h0), "post-reset nonmem");
        apply(mk(1, 1, 0, 4'd4, 32'd1040, 32'h0, 1, 1, 4'd4, 32'd1040, 32'hAA), "load 1040");
        check("addr_error after reset", 72'(addr_error), 72'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
